// File: rtl/instruction_fetch_unit_pkg.sv
// instruction_fetch_unit_pkg: fetch FSM states, queue entry layout and instruction size shared by the fetch unit
package instruction_fetch_unit_pkg;
  localparam int INSTR_BYTES = 4;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} fetch_state_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } fetch_entry_t;
endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// fetch_queue: registered sync FIFO of fetch entries with flush
// Ports: clk/rst (async active-high), flush empties the FIFO, push/din enqueue,
// pop dequeues the head, dout is the head entry, count/full/empty report occupancy.
module fetch_queue
  import instruction_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter type T = fetch_entry_t,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  T              din,
  output T              dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic push_ok, pop_ok;
  T mem_q [DEPTH];
  assign empty   = cnt_q == '0;
  assign full    = cnt_q == CW'(DEPTH);
  assign count   = cnt_q;
  assign pop_ok  = pop && !empty;
  // a pop in the same cycle frees the slot the push lands in
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem_q[rd_q];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(push_ok);
      rd_q  <= rd_q + AW'(pop_ok);
      cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  always_ff @(posedge clk)
    if (push_ok && !flush) mem_q[wr_q] <= din;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC generation, in-order imem requests and fetch queue feeding decode
// Ports: clk/rst (async active-high); imem_req_* request channel (addr = PC);
// imem_resp_* in-order response words; redirect_* new fetch PC (flushes and drops stale words);
// id_valid/id_ready handshake with instruction_addr/instruction as the queue head.
// Optional IFU_PERF_COUNTERS_EN adds fetch_stall_cycles and redirect_count (saturating).
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FETCH_QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [DATA_WIDTH-1:0] imem_resp_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [ADDR_WIDTH-1:0] instruction_addr,
  output logic [DATA_WIDTH-1:0] instruction
`ifdef IFU_PERF_COUNTERS_EN
  ,
  output logic [31:0]           fetch_stall_cycles,
  output logic [31:0]           redirect_count
`endif
);
  localparam int CW = $clog2(FETCH_QUEUE_DEPTH + 1);
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FETCH_QUEUE_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(INSTR_BYTES);
  fetch_state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, rpc_q, rpc_d;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, count;
  logic full, empty, req_fire, resp_keep;
  logic [EW-1:0] head;
  // credit counts queued plus in-flight words so every response has a slot
  assign imem_req_valid = state_q == S_FETCH && ({1'b0, count} + {1'b0, out_q} < DEPTH_C)
                          && !full && !redirect_valid;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_keep      = imem_resp_valid && drop_q == '0 && !redirect_valid;
  assign id_valid       = !empty;
  assign instruction_addr = empty ? '0 : head[EW-1 -: ADDR_WIDTH];
  assign instruction      = empty ? '0 : head[DATA_WIDTH-1:0];
  always_comb begin
    out_d   = out_q + CW'(req_fire) - CW'(imem_resp_valid);
    // on redirect every word still in flight after this cycle is stale
    drop_d  = redirect_valid ? out_q - CW'(imem_resp_valid)
                             : drop_q - CW'(imem_resp_valid && drop_q != '0);
    pc_d    = redirect_valid ? redirect_addr : req_fire ? pc_q + STEP : pc_q;
    rpc_d   = redirect_valid ? redirect_addr : resp_keep ? rpc_q + STEP : rpc_q;
    state_d = state_q == S_IDLE ? S_FETCH
            : (state_q == S_FETCH && !redirect_valid) ? S_FETCH
            : drop_d != '0 ? S_DRAIN : S_FETCH;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      rpc_q   <= RESET_PC;
      out_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rpc_q   <= rpc_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
    end
  fetch_queue #(.DEPTH(FETCH_QUEUE_DEPTH), .T(logic [EW-1:0]), .CW(CW)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (resp_keep),
    .pop   (id_valid && id_ready),
    .din   ({rpc_q, imem_resp_data}),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );
`ifdef IFU_PERF_COUNTERS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fetch_stall_cycles <= '0;
      redirect_count     <= '0;
    end else begin
      if (state_q == S_FETCH && !req_fire && fetch_stall_cycles != '1)
        fetch_stall_cycles <= fetch_stall_cycles + 32'd1;
      if (redirect_valid && redirect_count != '1)
        redirect_count <= redirect_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;
  logic clk = 0, rst = 0;
  logic imem_req_valid, imem_req_ready = 1;
  logic [31:0] imem_req_addr;
  logic imem_resp_valid = 0;
  logic [31:0] imem_resp_data = '0;
  logic redirect_valid = 0;
  logic [31:0] redirect_addr = '0;
  logic id_valid, id_ready = 1;
  logic [31:0] instruction_addr, instruction;
`ifdef IFU_PERF_COUNTERS_EN
  logic [31:0] fetch_stall_cycles, redirect_count;
`endif
  typedef struct {logic [31:0] addr; int due;} mreq_t;
  typedef struct {logic [31:0] addr; logic [31:0] data; int cyc;} dec_t;
  mreq_t mq[$];
  dec_t dq[$];
  logic [31:0] rq[$];
  int cyc = 0, lat = 1, n_cmp = 0, n_fail = 0, last_req_cyc = -1;
  logic saw_req_valid;
  logic [31:0] saw_req_addr;

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_resp_valid  (imem_resp_valid),
    .imem_resp_data   (imem_resp_data),
    .redirect_valid   (redirect_valid),
    .redirect_addr    (redirect_addr),
    .id_valid         (id_valid),
    .id_ready         (id_ready),
    .instruction_addr (instruction_addr),
    .instruction      (instruction)
`ifdef IFU_PERF_COUNTERS_EN
    ,
    .fetch_stall_cycles (fetch_stall_cycles),
    .redirect_count     (redirect_count)
`endif
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  // one clock: present any due response, sample handshakes, advance past the edge
  task automatic cycle();
    imem_resp_valid = 0;
    imem_resp_data  = '0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_resp_valid = 1;
      imem_resp_data  = word(mq[0].addr);
      void'(mq.pop_front());
    end
    #1;
    saw_req_valid = imem_req_valid;
    saw_req_addr  = imem_req_addr;
    if (imem_req_valid && imem_req_ready) begin
      mq.push_back('{imem_req_addr, cyc + lat});
      rq.push_back(imem_req_addr);
      last_req_cyc = cyc;
    end
    if (id_valid && id_ready) dq.push_back('{instruction_addr, instruction, cyc});
    @(posedge clk);
    #1;
    imem_resp_valid = 0;
    cyc++;
  endtask

  task automatic do_reset();
    redirect_valid = 0;
    imem_req_ready = 1;
    id_ready = 1;
    imem_resp_valid = 0;
    mq.delete();
    dq.delete();
    rq.delete();
    rst = 0;
    #1;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    #1;
    rst = 1;
    #2;
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
    n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid: got %b want 0", id_valid); end
    n_cmp++; if (instruction_addr !== 32'h0) begin n_fail++; $display("FAIL reset_instr_addr: got %h want 0", instruction_addr); end
    n_cmp++; if (instruction !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", instruction); end
    do_reset();
    lat = 1;
    cycle();
    n_cmp++; if (saw_req_valid !== 1'b0) begin n_fail++; $display("FAIL idle_req_valid: got %b want 0", saw_req_valid); end
    cycle();
    n_cmp++; if (saw_req_valid !== 1'b1 || saw_req_addr !== 32'h0) begin n_fail++; $display("FAIL first_req: got v=%b a=%h want v=1 a=0", saw_req_valid, saw_req_addr); end
  endtask

  task automatic test_sequential();
    repeat (8) cycle();
    n_cmp++;
    if (dq.size() < 3) begin n_fail++; $display("FAIL seq_count: got %0d want >=3", dq.size()); end
    else begin
      n_cmp++; if (dq[0].cyc !== 3) begin n_fail++; $display("FAIL seq_first_cycle: got %0d want 3", dq[0].cyc); end
      for (int i = 0; i < 3; i++) begin
        n_cmp++; if (dq[i].addr !== 32'(4 * i) || dq[i].data !== word(32'(4 * i))) begin n_fail++; $display("FAIL seq_word%0d: got %h/%h want %h/%h", i, dq[i].addr, dq[i].data, 4 * i, word(32'(4 * i))); end
        if (i > 0) begin
          n_cmp++; if (dq[i].cyc !== dq[i-1].cyc + 1) begin n_fail++; $display("FAIL seq_gap%0d: got %0d want %0d", i, dq[i].cyc, dq[i-1].cyc + 1); end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    lat = 1;
    id_ready = 0;
    repeat (12) cycle();
    n_cmp++; if (rq.size() !== 4) begin n_fail++; $display("FAIL bp_req_count: got %0d want 4", rq.size()); end
    n_cmp++; if (saw_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_valid: got %b want 0", saw_req_valid); end
    n_cmp++; if (id_valid !== 1'b1 || instruction_addr !== 32'h0) begin n_fail++; $display("FAIL bp_head: got v=%b a=%h want v=1 a=0", id_valid, instruction_addr); end
    id_ready = 1;
    repeat (20) cycle();
    n_cmp++;
    if (dq.size() < 8 || rq.size() < 8) begin n_fail++; $display("FAIL bp_resume_count: got dq=%0d rq=%0d want >=8", dq.size(), rq.size()); end
    else for (int i = 0; i < 8; i++) begin
      n_cmp++; if (rq[i] !== 32'(4 * i)) begin n_fail++; $display("FAIL bp_req%0d: got %h want %h", i, rq[i], 4 * i); end
      n_cmp++; if (dq[i].addr !== 32'(4 * i) || dq[i].data !== word(32'(4 * i))) begin n_fail++; $display("FAIL bp_word%0d: got %h/%h want %h/%h", i, dq[i].addr, dq[i].data, 4 * i, word(32'(4 * i))); end
    end
  endtask

  task automatic test_drain();
    int r;
    do_reset();
    lat = 4;
    for (int k = 0; k < 20 && rq.size() < 3; k++) cycle();
    n_cmp++; if (rq.size() !== 3 || dq.size() !== 0) begin n_fail++; $display("FAIL drain_setup: got rq=%0d dq=%0d want 3/0", rq.size(), dq.size()); end
    r = cyc;
    rq.delete();
    redirect_valid = 1;
    redirect_addr = 32'h100;
    cycle();
    redirect_valid = 0;
    n_cmp++; if (saw_req_valid !== 1'b0) begin n_fail++; $display("FAIL drain_redirect_req: got %b want 0", saw_req_valid); end
    for (int k = 0; k < 20 && rq.size() == 0; k++) cycle();
    n_cmp++; if (rq.size() == 0 || rq[0] !== 32'h100) begin n_fail++; $display("FAIL drain_new_req: got n=%0d want addr 100", rq.size()); end
    n_cmp++; if (last_req_cyc !== r + 4) begin n_fail++; $display("FAIL drain_len: got cycle %0d want %0d", last_req_cyc, r + 4); end
    repeat (10) cycle();
    n_cmp++; if (dq.size() == 0 || dq[0].addr !== 32'h100 || dq[0].data !== word(32'h100)) begin n_fail++; $display("FAIL drain_first_decode: got n=%0d want addr 100", dq.size()); end
  endtask

  task automatic test_redirect_with_resp();
    logic [31:0] w;
    bit seen;
    do_reset();
    lat = 2;
    id_ready = 0;
    for (int k = 0; k < 20 && !(mq.size() > 0 && mq[0].due <= cyc && id_valid); k++) cycle();
    n_cmp++; if (!(mq.size() > 0 && mq[0].due <= cyc && id_valid)) begin n_fail++; $display("FAIL rr_setup: got no overlapping response want one"); end
    w = mq.size() > 0 ? mq[0].addr : 32'h0;
    redirect_valid = 1;
    redirect_addr = 32'h200;
    cycle();
    redirect_valid = 0;
    n_cmp++; if (saw_req_valid !== 1'b0) begin n_fail++; $display("FAIL rr_req_valid: got %b want 0", saw_req_valid); end
    n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rr_flush: got %b want 0", id_valid); end
    id_ready = 1;
    repeat (15) cycle();
    n_cmp++;
    if (dq.size() < 2) begin n_fail++; $display("FAIL rr_count: got %0d want >=2", dq.size()); end
    else begin
      n_cmp++; if (dq[0].addr !== 32'h200 || dq[1].addr !== 32'h204) begin n_fail++; $display("FAIL rr_order: got %h,%h want 200,204", dq[0].addr, dq[1].addr); end
    end
    seen = 0;
    foreach (dq[i]) if (dq[i].addr == w) seen = 1;
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rr_stale: got word %h at decode want absent", w); end
  endtask

  task automatic test_wrap();
    bit seen;
    do_reset();
    lat = 1;
    for (int k = 0; k < 20 && rq.size() < 6; k++) cycle();
    dq.delete();
    rq.delete();
    redirect_valid = 1;
    redirect_addr = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 0;
    repeat (8) cycle();
    n_cmp++; if (rq.size() < 2 || rq[0] !== 32'hFFFF_FFFC || rq[1] !== 32'h0) begin n_fail++; $display("FAIL wrap_req: got n=%0d want FFFFFFFC then 0", rq.size()); end
    n_cmp++;
    if (dq.size() < 3) begin n_fail++; $display("FAIL wrap_count: got %0d want >=3", dq.size()); end
    else begin
      n_cmp++; if (dq[0].addr !== 32'h10 || dq[0].data !== word(32'h10)) begin n_fail++; $display("FAIL wrap_redirect_deq: got %h want 10", dq[0].addr); end
      n_cmp++; if (dq[1].addr !== 32'hFFFF_FFFC || dq[1].data !== word(32'hFFFF_FFFC)) begin n_fail++; $display("FAIL wrap_top: got %h want FFFFFFFC", dq[1].addr); end
      n_cmp++; if (dq[2].addr !== 32'h0 || dq[2].data !== word(32'h0)) begin n_fail++; $display("FAIL wrap_zero: got %h want 0", dq[2].addr); end
    end
    seen = 0;
    foreach (dq[i]) if (dq[i].addr == 32'h14) seen = 1;
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL wrap_stale: got 14 at decode want absent"); end
  endtask

`ifdef IFU_PERF_COUNTERS_EN
  task automatic test_perf();
    do_reset();
    n_cmp++; if (fetch_stall_cycles !== 32'h0 || redirect_count !== 32'h0) begin n_fail++; $display("FAIL perf_reset: got %0d/%0d want 0/0", fetch_stall_cycles, redirect_count); end
    lat = 1;
    imem_req_ready = 0;
    repeat (6) cycle();
    imem_req_ready = 1;
    repeat (2) cycle();
    redirect_valid = 1;
    redirect_addr = 32'h40;
    cycle();
    redirect_valid = 0;
    cycle();
    redirect_valid = 1;
    redirect_addr = 32'h80;
    cycle();
    redirect_valid = 0;
    repeat (3) cycle();
    n_cmp++; if (fetch_stall_cycles < 32'd5) begin n_fail++; $display("FAIL perf_stall: got %0d want >=5", fetch_stall_cycles); end
    n_cmp++; if (redirect_count !== 32'd2) begin n_fail++; $display("FAIL perf_redirects: got %0d want 2", redirect_count); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_drain();
    test_redirect_with_resp();
    test_wrap();
`ifdef IFU_PERF_COUNTERS_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
